// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Drives the EX-stage busy signal for the hazard unit.
module md_unit #(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  localparam int MAX_CYC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES,
  localparam int CNT_W = $clog2(MAX_CYC + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0] MULT_L = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_L  = CNT_W'(DIV_CYCLES);

  localparam logic [DATA_W-1:0] MIN_NEG =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONE =
    {{(DATA_W-1){1'b0}}, 1'b1};

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] pend_hi;
  logic [DATA_W-1:0] pend_lo;
  logic              pend_wr;

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic [DATA_W-1:0]   div_b;
  logic [DATA_W-1:0]   qs;
  logic [DATA_W-1:0]   rs;
  logic                b_zero;
  logic                ovf;
  logic                accept_md;

  logic [DATA_W-1:0] nxt_hi;
  logic [DATA_W-1:0] nxt_lo;
  logic              nxt_wr;
  logic [CNT_W-1:0]  nxt_len;

  assign busy   = (state == S_RUN);
  assign b_zero = (src_b == '0);
  assign ovf    = (src_a == MIN_NEG) && (src_b == '1);
  // divisor forced nonzero so the datapath never sees x/0
  assign div_b  = b_zero ? ONE : src_b;

  assign prod_s =
    $signed({{DATA_W{src_a[DATA_W-1]}}, src_a}) *
    $signed({{DATA_W{src_b[DATA_W-1]}}, src_b});
  assign prod_u =
    {{DATA_W{1'b0}}, src_a} * {{DATA_W{1'b0}}, src_b};
  assign qs = $signed(src_a) / $signed(div_b);
  assign rs = $signed(src_a) % $signed(div_b);

  assign accept_md = (state == S_IDLE) && start && (op <= OP_DIVU);

  // result and latency for the op being accepted
  always_comb begin
    nxt_hi  = '0;
    nxt_lo  = '0;
    nxt_wr  = 1'b1;
    nxt_len = MULT_L;
    unique case (op)
      OP_MULT:  {nxt_hi, nxt_lo} = prod_s;
      OP_MULTU: {nxt_hi, nxt_lo} = prod_u;
      OP_DIV: begin
        nxt_len = DIV_L;
        if (b_zero) begin
          nxt_wr = 1'b0;
        end else if (ovf) begin
          nxt_lo = MIN_NEG;
          nxt_hi = '0;
        end else begin
          nxt_lo = qs;
          nxt_hi = rs;
        end
      end
      OP_DIVU: begin
        nxt_len = DIV_L;
        nxt_wr  = !b_zero;
        nxt_lo  = src_a / div_b;
        nxt_hi  = src_a % div_b;
      end
      default: ;
    endcase
  end

  // IDLE/RUN control, latency counter and HI/LO update
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (state == S_IDLE) begin
      if (accept_md) begin
        pend_hi <= nxt_hi;
        pend_lo <= nxt_lo;
        pend_wr <= nxt_wr;
        cnt     <= nxt_len;
        state   <= S_RUN;
      end else if (start && op == OP_MTHI) begin
        hi <= src_a;
      end else if (start && op == OP_MTLO) begin
        lo <= src_a;
      end
    end else begin
      cnt <= cnt - 1'b1;
      if (cnt == ONE[CNT_W-1:0]) begin
        state <= S_IDLE;
        if (pend_wr) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end
  end

endmodule
